// File: rtl/latch_alu_uart_stream_if.sv
// Operand/strobe bus and status/serial outputs of latch_alu_uart_stream.
// master drives operands and strobes; slave is the datapath.
interface latch_alu_uart_stream_if #(
   parameter int DATA_W = 4
);
   localparam int RES_W = 2 * DATA_W;

   logic              save_a;
   logic              save_b;
   logic [DATA_W-1:0] data_in;
   logic [1:0]        op;
   logic              calc;
   logic [RES_W-1:0]  result;
   logic              result_valid;
   logic              fifo_full;
   logic              fifo_empty;
   logic              overflow;
   logic              uart_txd;
   logic              uart_busy;

   modport master (
      output save_a, save_b, data_in, op, calc,
      input  result, result_valid, fifo_full, fifo_empty, overflow, uart_txd, uart_busy
   );

   modport slave (
      input  save_a, save_b, data_in, op, calc,
      output result, result_valid, fifo_full, fifo_empty, overflow, uart_txd, uart_busy
   );
endinterface

// File: rtl/latch_alu_uart_stream.sv
// Operand latches + 4-op ALU feeding a result FIFO, drained by a UART
// transmitter that sends each result as RES_BYTES frames, LSB byte first.
module latch_alu_uart_stream #(
   parameter int DATA_W     = 4,
   parameter int FIFO_DEPTH = 8,
   parameter int CLK_DIV    = 434,
   parameter int PARITY_EN  = 0
) (
   input  logic                    clk,
   input  logic                    reset,
   latch_alu_uart_stream_if.slave  bus
);
   localparam int RES_W     = 2 * DATA_W;
   localparam int RES_BYTES = (RES_W + 7) / 8;
   localparam int SHIFT_W   = RES_BYTES * 8;
   localparam int PTR_W     = $clog2(FIFO_DEPTH);
   localparam int CNT_W     = PTR_W + 1;
   localparam int DIV_W     = $clog2(CLK_DIV);
   localparam int BIDX_W    = $clog2(RES_BYTES + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   logic [DATA_W-1:0]  a_q, b_q;
   logic [RES_W-1:0]   alu_res;
   logic [RES_W-1:0]   result_q;
   logic               result_valid_q;

   logic [RES_W-1:0]   mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr, rd_ptr;
   logic [CNT_W-1:0]   count;
   logic               overflow_q;
   logic               fifo_full, fifo_empty;
   logic               push, pop;

   state_t             state_q, state_d;
   logic [DIV_W-1:0]   div_q;
   logic               bit_end;
   logic [2:0]         bit_q;
   logic [BIDX_W-1:0]  byte_q;
   logic [SHIFT_W-1:0] shreg_q;
   logic               par_q;
   logic               txd_q, txd_d;

   always_comb begin
      alu_res = '0;
      case (bus.op)
         2'b00:   alu_res = RES_W'(a_q) + RES_W'(b_q);
         2'b01:   alu_res = RES_W'(a_q) - RES_W'(b_q);
         2'b10:   alu_res = RES_W'(a_q) * RES_W'(b_q);
         default: alu_res = RES_W'(a_q & b_q);
      endcase
   end

   // calc sees the operands from before any same-cycle save strobe
   always_ff @(posedge clk) begin
      if (reset) begin
         a_q            <= '0;
         b_q            <= '0;
         result_q       <= '0;
         result_valid_q <= 1'b0;
      end else begin
         if (bus.save_a) a_q <= bus.data_in;
         if (bus.save_b) b_q <= bus.data_in;
         result_valid_q <= bus.calc;
         if (bus.calc) result_q <= alu_res;
      end
   end

   assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
   assign fifo_empty = (count == '0);
   // a pop in the same cycle frees the slot, so a full FIFO still accepts
   assign push       = bus.calc && (!fifo_full || pop);

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= alu_res;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (push && !pop)      count <= count + CNT_W'(1);
         else if (!push && pop) count <= count - CNT_W'(1);
         if (bus.calc && !push) overflow_q <= 1'b1;
      end
   end

   assign bit_end = (div_q == DIV_W'(CLK_DIV - 1));

   always_comb begin
      state_d = state_q;
      txd_d   = txd_q;
      pop     = 1'b0;
      case (state_q)
         S_IDLE: begin
            txd_d = 1'b1;
            if (!fifo_empty) begin
               pop     = 1'b1;
               state_d = S_START;
               txd_d   = 1'b0;
            end
         end
         S_START: if (bit_end) begin
            state_d = S_DATA;
            txd_d   = shreg_q[0];
         end
         S_DATA: if (bit_end) begin
            if (bit_q == 3'd7) begin
               if (PARITY_EN != 0) begin
                  state_d = S_PARITY;
                  txd_d   = par_q;
               end else begin
                  state_d = S_STOP;
                  txd_d   = 1'b1;
               end
            end else begin
               txd_d = shreg_q[1];
            end
         end
         S_PARITY: if (bit_end) begin
            state_d = S_STOP;
            txd_d   = 1'b1;
         end
         S_STOP: if (bit_end) begin
            if (byte_q != BIDX_W'(RES_BYTES - 1)) begin
               state_d = S_START;
               txd_d   = 1'b0;
            end else begin
               state_d = S_IDLE;
               txd_d   = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            txd_d   = 1'b1;
         end
      endcase
   end

   // shreg shifts one bit per data bit, so after 8 shifts the next byte sits at [7:0]
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         txd_q   <= 1'b1;
         div_q   <= '0;
         bit_q   <= '0;
         byte_q  <= '0;
         shreg_q <= '0;
         par_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         txd_q   <= txd_d;
         if (state_q == S_IDLE || bit_end) div_q <= '0;
         else                              div_q <= div_q + DIV_W'(1);
         case (state_q)
            S_IDLE: if (pop) begin
               shreg_q <= SHIFT_W'(mem[rd_ptr]);
               byte_q  <= '0;
            end
            S_START: if (bit_end) begin
               bit_q <= '0;
               par_q <= ^shreg_q[7:0];
            end
            S_DATA: if (bit_end) begin
               shreg_q <= shreg_q >> 1;
               bit_q   <= bit_q + 3'd1;
            end
            S_STOP: if (bit_end && state_d == S_START) byte_q <= byte_q + BIDX_W'(1);
            default: ;
         endcase
      end
   end

   assign bus.result       = result_q;
   assign bus.result_valid = result_valid_q;
   assign bus.fifo_full    = fifo_full;
   assign bus.fifo_empty   = fifo_empty;
   assign bus.overflow     = overflow_q;
   assign bus.uart_txd     = txd_q;
   assign bus.uart_busy    = (state_q != S_IDLE);
endmodule

// File: tb/tb_latch_alu_uart_stream.sv
// Directed bench: 4-bit/no-parity instance (u0) and 8-bit/even-parity instance (u1),
// both with CLK_DIV=4 and a 4-entry FIFO.
module tb_latch_alu_uart_stream;
   localparam int DIV = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   latch_alu_uart_stream_if #(.DATA_W(4)) if0 ();
   latch_alu_uart_stream_if #(.DATA_W(8)) if1 ();

   latch_alu_uart_stream #(.DATA_W(4), .FIFO_DEPTH(4), .CLK_DIV(DIV), .PARITY_EN(0)) u0 (
      .clk(clk), .reset(reset), .bus(if0)
   );
   latch_alu_uart_stream #(.DATA_W(8), .FIFO_DEPTH(4), .CLK_DIV(DIV), .PARITY_EN(1)) u1 (
      .clk(clk), .reset(reset), .bus(if1)
   );

   function automatic logic txd_of(input int dut);
      return (dut == 0) ? if0.uart_txd : if1.uart_txd;
   endfunction

   // one clock of stimulus on u0, ending at the following negedge with strobes low
   task automatic cyc0(input logic sa, input logic sb, input logic c, input logic [3:0] d,
                       input logic [1:0] o);
      if0.save_a = sa; if0.save_b = sb; if0.calc = c; if0.data_in = d; if0.op = o;
      @(negedge clk);
      if0.save_a = 1'b0; if0.save_b = 1'b0; if0.calc = 1'b0;
   endtask

   task automatic cyc1(input logic sa, input logic sb, input logic c, input logic [7:0] d,
                       input logic [1:0] o);
      if1.save_a = sa; if1.save_b = sb; if1.calc = c; if1.data_in = d; if1.op = o;
      @(negedge clk);
      if1.save_a = 1'b0; if1.save_b = 1'b0; if1.calc = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   // waits for a start bit, then checks every cycle of every bit; returns idle wait length
   task automatic rx_frame(input int dut, input logic [7:0] byte_v, input bit with_par,
                           input string tag, output int waited);
      logic [10:0] bits;
      int          nb;
      int          w;
      bit          ok;
      logic        seen;
      bits = '1;
      bits[0] = 1'b0;
      for (int k = 0; k < 8; k++) bits[k+1] = byte_v[k];
      if (with_par) bits[9] = ^byte_v;
      nb = with_par ? 11 : 10;
      w = 0;
      while (txd_of(dut) !== 1'b0 && w < 400) begin
         @(negedge clk);
         w++;
      end
      waited = w;
      n_cmp++;
      if (txd_of(dut) !== 1'b0) begin
         n_bad++;
         $display("FAIL %s start_bit: txd=%b after %0d cycles, required 0", tag, txd_of(dut), w);
         return;
      end
      for (int b = 0; b < nb; b++) begin
         ok = 1'b1;
         seen = bits[b];
         for (int c = 0; c < DIV; c++) begin
            if (txd_of(dut) !== bits[b]) begin
               ok = 1'b0;
               seen = txd_of(dut);
            end
            @(negedge clk);
         end
         n_cmp++;
         if (!ok) begin
            n_bad++;
            $display("FAIL %s bit%0d: txd=%b, required %b for %0d cycles", tag, b, seen, bits[b], DIV);
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      n_cmp += 7;
      if (if0.result !== 8'h00) begin n_bad++; $display("FAIL rst_result: %h vs 00", if0.result); end
      if (if0.result_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: %b vs 0", if0.result_valid); end
      if (if0.fifo_empty !== 1'b1) begin n_bad++; $display("FAIL rst_empty: %b vs 1", if0.fifo_empty); end
      if (if0.fifo_full !== 1'b0) begin n_bad++; $display("FAIL rst_full: %b vs 0", if0.fifo_full); end
      if (if0.overflow !== 1'b0) begin n_bad++; $display("FAIL rst_overflow: %b vs 0", if0.overflow); end
      if (if0.uart_txd !== 1'b1) begin n_bad++; $display("FAIL rst_txd: %b vs 1", if0.uart_txd); end
      if (if0.uart_busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: %b vs 0", if0.uart_busy); end
      reset = 1'b0;
   endtask

   task automatic test_add_frame();
      int w;
      do_reset();
      cyc0(1, 0, 0, 4'd9, 2'b00);
      cyc0(0, 1, 0, 4'd7, 2'b00);
      cyc0(0, 0, 1, 4'd0, 2'b00);
      n_cmp += 2;
      if (if0.result !== 8'h10) begin n_bad++; $display("FAIL add_result: %h vs 10", if0.result); end
      if (if0.result_valid !== 1'b1) begin n_bad++; $display("FAIL add_valid: %b vs 1", if0.result_valid); end
      rx_frame(0, 8'h10, 1'b0, "add_frame", w);
      n_cmp += 2;
      if (if0.uart_busy !== 1'b0) begin n_bad++; $display("FAIL add_busy_after: %b vs 0", if0.uart_busy); end
      if (if0.fifo_empty !== 1'b1) begin n_bad++; $display("FAIL add_empty_after: %b vs 1", if0.fifo_empty); end
   endtask

   task automatic test_ops();
      do_reset();
      cyc0(1, 0, 0, 4'd3, 2'b00);
      cyc0(0, 1, 0, 4'd5, 2'b00);
      cyc0(0, 0, 1, 4'd0, 2'b01);
      n_cmp++;
      if (if0.result !== 8'hFE) begin n_bad++; $display("FAIL sub_result: %h vs fe", if0.result); end
      @(negedge clk);
      n_cmp++;
      if (if0.result_valid !== 1'b0) begin n_bad++; $display("FAIL valid_pulse: %b vs 0", if0.result_valid); end
      cyc0(1, 1, 0, 4'd15, 2'b00);
      cyc0(0, 0, 1, 4'd0, 2'b10);
      n_cmp++;
      if (if0.result !== 8'hE1) begin n_bad++; $display("FAIL mul_result: %h vs e1", if0.result); end
      cyc0(1, 0, 0, 4'd12, 2'b00);
      cyc0(0, 1, 0, 4'd10, 2'b00);
      cyc0(0, 0, 1, 4'd0, 2'b11);
      n_cmp += 2;
      if (if0.result !== 8'h08) begin n_bad++; $display("FAIL and_result: %h vs 08", if0.result); end
      if (if0.overflow !== 1'b0) begin n_bad++; $display("FAIL ops_overflow: %b vs 0", if0.overflow); end
   endtask

   task automatic test_back_to_back();
      int w;
      do_reset();
      cyc0(0, 1, 0, 4'd8, 2'b00);
      fork
         begin
            // each calc adds the pre-save A (0..5) to B=8, giving 8..13
            for (int i = 0; i < 6; i++) cyc0(1, 0, 1, 4'(i + 1), 2'b00);
            n_cmp += 2;
            if (if0.overflow !== 1'b1) begin n_bad++; $display("FAIL b2b_overflow: %b vs 1", if0.overflow); end
            if (if0.fifo_full !== 1'b1) begin n_bad++; $display("FAIL b2b_full: %b vs 1", if0.fifo_full); end
         end
         begin
            for (int i = 0; i < 5; i++) rx_frame(0, 8'(8 + i), 1'b0, $sformatf("b2b_frame%0d", i), w);
         end
      join
      repeat (20) @(negedge clk);
      n_cmp += 3;
      if (if0.fifo_empty !== 1'b1) begin n_bad++; $display("FAIL b2b_empty: %b vs 1", if0.fifo_empty); end
      if (if0.uart_busy !== 1'b0) begin n_bad++; $display("FAIL b2b_no_sixth: busy=%b vs 0", if0.uart_busy); end
      if (if0.overflow !== 1'b1) begin n_bad++; $display("FAIL b2b_sticky: %b vs 1", if0.overflow); end
   endtask

   task automatic test_calc_with_save();
      do_reset();
      cyc0(1, 1, 0, 4'd1, 2'b00);
      cyc0(1, 0, 1, 4'd2, 2'b00);
      n_cmp++;
      if (if0.result !== 8'h02) begin n_bad++; $display("FAIL calc_old_a: %h vs 02", if0.result); end
      cyc0(0, 0, 1, 4'd0, 2'b00);
      n_cmp++;
      if (if0.result !== 8'h03) begin n_bad++; $display("FAIL a_updated: %h vs 03", if0.result); end
   endtask

   task automatic test_multibyte_parity();
      int w;
      do_reset();
      cyc1(1, 0, 0, 8'd200, 2'b00);
      cyc1(0, 1, 0, 8'd100, 2'b00);
      cyc1(0, 0, 1, 8'd0, 2'b10);
      n_cmp++;
      if (if1.result !== 16'h4E20) begin n_bad++; $display("FAIL mul16_result: %h vs 4e20", if1.result); end
      rx_frame(1, 8'h20, 1'b1, "par_byte0", w);
      rx_frame(1, 8'h4E, 1'b1, "par_byte1", w);
      n_cmp += 2;
      if (w !== 0) begin n_bad++; $display("FAIL byte_gap: %0d idle cycles vs 0", w); end
      if (if1.uart_busy !== 1'b0) begin n_bad++; $display("FAIL mb_busy_after: %b vs 0", if1.uart_busy); end
   endtask

   task automatic test_reset_mid_frame();
      int  w;
      bit  quiet;
      do_reset();
      cyc0(1, 0, 0, 4'd9, 2'b00);
      cyc0(0, 1, 0, 4'd7, 2'b00);
      cyc0(0, 0, 1, 4'd0, 2'b00);
      cyc0(0, 0, 1, 4'd0, 2'b00);
      w = 0;
      while (if0.uart_txd !== 1'b0 && w < 50) begin @(negedge clk); w++; end
      repeat (DIV + 2) @(negedge clk);
      n_cmp++;
      if (if0.uart_busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy: %b vs 1", if0.uart_busy); end
      reset = 1'b1;
      @(negedge clk);
      n_cmp += 3;
      if (if0.uart_txd !== 1'b1) begin n_bad++; $display("FAIL mid_rst_txd: %b vs 1", if0.uart_txd); end
      if (if0.uart_busy !== 1'b0) begin n_bad++; $display("FAIL mid_rst_busy: %b vs 0", if0.uart_busy); end
      if (if0.fifo_empty !== 1'b1) begin n_bad++; $display("FAIL mid_rst_empty: %b vs 1", if0.fifo_empty); end
      reset = 1'b0;
      quiet = 1'b1;
      for (int i = 0; i < 60; i++) begin
         if (if0.uart_txd !== 1'b1 || if0.uart_busy !== 1'b0) quiet = 1'b0;
         @(negedge clk);
      end
      n_cmp++;
      if (!quiet) begin n_bad++; $display("FAIL mid_rst_quiet: line active=1 vs 0"); end
   endtask

   initial begin
      if0.save_a = 1'b0; if0.save_b = 1'b0; if0.calc = 1'b0; if0.data_in = '0; if0.op = '0;
      if1.save_a = 1'b0; if1.save_b = 1'b0; if1.calc = 1'b0; if1.data_in = '0; if1.op = '0;
      test_reset();
      test_add_frame();
      test_ops();
      test_back_to_back();
      test_calc_with_save();
      test_multibyte_parity();
      test_reset_mid_frame();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
